b2to1_packet_arbiter: RTL and testbench

//  Round-robin arbiter sharing one output channel between two packet sources.

---
 rtl/b2to1_packet_arbiter_if.sv | 46 ++++
 rtl/b2to1_packet_arbiter.sv | 96 +++++++++
 tb/tb_b2to1_packet_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b2to1_packet_arbiter_if.sv
// Bundle of every handshake and bus signal around the 2:1 packet arbiter.
//   in0_*  : source 0 channel (data/valid/last in, ready out of the arbiter)
//   in1_*  : source 1 channel (data/valid/last in, ready out of the arbiter)
//   out_*  : shared consumer channel (data/valid/last out, ready in)
//   sel    : registered mux select (current or most recent grant)
//   busy   : 1 while a grant is held
// The master modport is the arbiter side. The slave modport is the
// environment side: the producers and the consumer.
interface b2to1_packet_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0_data;
  logic             in0_valid;
  logic             in0_last;
  logic             in0_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_valid;
  logic             in1_last;
  logic             in1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             sel;
  logic             busy;

  modport master (
    input  in0_data, in0_valid, in0_last,
    output in0_ready,
    input  in1_data, in1_valid, in1_last,
    output in1_ready,
    output out_data, out_valid, out_last,
    input  out_ready,
    output sel, busy
  );

  modport slave (
    output in0_data, in0_valid, in0_last,
    input  in0_ready,
    output in1_data, in1_valid, in1_last,
    input  in1_ready,
    input  out_data, out_valid, out_last,
    output out_ready,
    input  sel, busy
  );
endinterface

// File: rtl/b2to1_packet_arbiter.sv
// Round-robin arbiter that shares one output channel between two packet
// sources. A grant is held for a whole packet, or for at most MAX_BEATS beats.
// When the beat limit is reached the grant is released and out_last is forced
// on that beat. The rest of that packet is then arbitrated as a new packet.
// Ports:
//   clock : single clock; all state changes on the rising edge
//   reset : synchronous reset, active-high
//   bus   : b2to1_packet_arbiter_if.master. It carries both source channels,
//           the output channel, sel and busy.
module b2to1_packet_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  b2to1_packet_arbiter_if.master bus
);
  localparam int                 CNT_W    = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic             sel_q, sel_nxt;
  logic             ptr_q, ptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic g_valid;
  logic g_last;
  logic at_max;
  logic active;
  logic accept;

  // State register: state, select, priority pointer and beat count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= 1'b0;
      ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      ptr_q <= ptr_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Next-state logic and the output mux.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;

    g_valid = sel_q ? bus.in1_valid : bus.in0_valid;
    g_last  = sel_q ? bus.in1_last  : bus.in0_last;
    at_max  = (cnt_q == LAST_CNT);
    // Gating with reset stops any beat from being offered or accepted in the
    // cycle where reset is asserted mid-packet.
    active  = (state == GRANT) && !reset;
    accept  = active && g_valid && bus.out_ready;

    bus.out_data  = sel_q ? bus.in1_data : bus.in0_data;
    bus.out_valid = active && g_valid;
    bus.out_last  = active && (g_last || at_max);
    bus.in0_ready = active && !sel_q && bus.out_ready;
    bus.in1_ready = active &&  sel_q && bus.out_ready;
    bus.sel       = sel_q;
    bus.busy      = (state == GRANT);

    case (state)
      IDLE: begin
        if (bus.in0_valid || bus.in1_valid) begin
          // If only one source is valid it wins. If both are valid, the
          // source that ptr_q points to wins.
          sel_nxt   = (bus.in0_valid && bus.in1_valid) ? ptr_q : bus.in1_valid;
          state_nxt = GRANT;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (g_last || at_max) begin
            state_nxt = IDLE;
            ptr_nxt   = ~sel_q;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_b2to1_packet_arbiter.sv
module tb_b2to1_packet_arbiter;
  localparam int W    = 8;
  localparam int MAXB = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  b2to1_packet_arbiter_if #(.WIDTH(W)) bus ();

  b2to1_packet_arbiter #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       s;
    int         c;
  } beat_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int mark;
  bit chk_on = 0;

  // Stimulus knobs. Each source is a queue of {last, data} beats.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit en0 = 0, en1 = 0, rdy_k = 0, rst_k = 1;
  beat_t blog[$];

  // Behavioural model: who owns the channel, who is preferred next, and how
  // many beats the current grant has moved.
  int m_owner = -1;
  bit m_pref  = 0;
  bit m_sel   = 0;
  int m_beats = 0;

  // DUT handshake values latched at the falling edge, used at the next
  // rising edge.
  bit d_acc0 = 0, d_acc1 = 0, d_acc = 0, d_last = 0, d_sel = 0;
  logic [7:0] d_data = '0;
  bit exp_v, exp_l;

  int e2[12] = '{'h01, 'h02, 'h11, 'h12, 'h03, 'h04, 'h13, 'h14, 'h05, 'h06, 'h15, 'h16};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply();
    reset         = rst_k;
    bus.out_ready = rdy_k;
    bus.in0_valid = en0 && (q0.size() > 0);
    bus.in0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.in0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.in1_valid = en1 && (q1.size() > 0);
    bus.in1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.in1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  task automatic model_step();
    bit v0, v1, gv, gl;
    if (reset) begin
      m_owner = -1; m_pref = 0; m_sel = 0; m_beats = 0;
      return;
    end
    v0 = bus.in0_valid;
    v1 = bus.in1_valid;
    if (m_owner < 0) begin
      if (v0 && v1)  m_owner = int'(m_pref);
      else if (v0)   m_owner = 0;
      else if (v1)   m_owner = 1;
      if (m_owner >= 0) begin
        m_sel   = (m_owner == 1);
        m_beats = 0;
      end
    end else begin
      gv = (m_owner == 1) ? v1 : v0;
      if (gv && bus.out_ready) begin
        gl = (m_owner == 1) ? bus.in1_last : bus.in0_last;
        if (gl || m_beats == MAXB - 1) begin
          m_pref  = (m_owner == 0);
          m_owner = -1;
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    model_step();
    if (d_acc) blog.push_back('{d_data, d_last, d_sel, cyc});
    if (d_acc0 && q0.size() > 0) q0.delete(0);
    if (d_acc1 && q1.size() > 0) q1.delete(0);
    #1;
    apply();
  endtask

  task automatic do_reset();
    rst_k = 1; en0 = 0; en1 = 0;
    q0.delete(); q1.delete();
    apply();
    tick();
    rst_k = 0;
    apply();
    blog.delete();
  endtask

  // Per-cycle comparison of the DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      exp_v = (m_owner >= 0) && !reset && ((m_owner == 1) ? bus.in1_valid : bus.in0_valid);
      exp_l = ((m_owner == 1) ? bus.in1_last : bus.in0_last) || (m_beats == MAXB - 1);
      chk("busy", bus.busy, m_owner >= 0);
      chk("sel", bus.sel, m_sel);
      chk("out_valid", bus.out_valid, exp_v);
      chk("in0_ready", bus.in0_ready, (m_owner == 0) && !reset && bus.out_ready);
      chk("in1_ready", bus.in1_ready, (m_owner == 1) && !reset && bus.out_ready);
      if (exp_v) begin
        chk("out_data", bus.out_data, (m_owner == 1) ? bus.in1_data : bus.in0_data);
        chk("out_last", bus.out_last, exp_l);
      end
    end
    d_acc0 = bus.in0_valid && bus.in0_ready;
    d_acc1 = bus.in1_valid && bus.in1_ready;
    d_acc  = bus.out_valid && bus.out_ready;
    d_data = bus.out_data;
    d_last = bus.out_last;
    d_sel  = bus.sel;
  end

  initial begin
    apply();
    tick();
    chk_on = 1;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in0_ready", bus.in0_ready, 0);
    chk("rst_in1_ready", bus.in1_ready, 0);
    rst_k = 0;
    apply();

    // 1: single 3-beat packet on source 0
    q0 = '{9'h0A0, 9'h0A1, 9'h1A2};
    en0 = 1; rdy_k = 1; mark = cyc; blog.delete();
    apply();
    repeat (4) tick();
    chk("t1_busy_after", bus.busy, 0);
    chk("t1_count", blog.size(), 3);
    if (blog.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_data", blog[i].d, 8'hA0 + 8'(i));
        chk("t1_cycle", blog[i].c, mark + 2 + i);
        chk("t1_last", blog[i].l, (i == 2));
        chk("t1_sel", blog[i].s, 0);
      end
    end

    // 2: both sources busy from reset, strict alternation
    do_reset();
    for (int p = 0; p < 3; p++) begin
      q0.push_back({1'b0, 8'(2 * p + 1)});
      q0.push_back({1'b1, 8'(2 * p + 2)});
      q1.push_back({1'b0, 8'(8'h11 + 2 * p)});
      q1.push_back({1'b1, 8'(8'h12 + 2 * p)});
    end
    en0 = 1; en1 = 1; rdy_k = 1;
    apply();
    repeat (20) tick();
    chk("t2_count", blog.size(), 12);
    if (blog.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("t2_data", blog[i].d, e2[i]);
        chk("t2_src", blog[i].s, (i % 4) >= 2);
      end
    end

    // 3: 20-beat packet on source 1, forced release after 16 beats
    do_reset();
    for (int i = 0; i < 20; i++) q1.push_back({(i == 19), 8'(8'h20 + i)});
    q0 = '{9'h040, 9'h141};
    en1 = 1; rdy_k = 1;
    apply();
    repeat (2) tick();
    en0 = 1;
    apply();
    repeat (26) tick();
    chk("t3_count", blog.size(), 22);
    if (blog.size() == 22) begin
      chk("t3_forced_data", blog[15].d, 8'h2F);
      chk("t3_forced_last", blog[15].l, 1);
      chk("t3_beat14_last", blog[14].l, 0);
      chk("t3_src0_data", blog[16].d, 8'h40);
      chk("t3_src0_sel", blog[16].s, 0);
      chk("t3_rest_data", blog[18].d, 8'h30);
      chk("t3_rest_sel", blog[18].s, 1);
      chk("t3_tail_data", blog[21].d, 8'h33);
      chk("t3_tail_last", blog[21].l, 1);
    end

    // 4: out_ready toggling plus one valid drop mid-packet
    do_reset();
    q0 = '{9'h050, 9'h051, 9'h052, 9'h153};
    for (int i = 0; i < 12; i++) begin
      rdy_k = (i % 2 == 0);
      en0 = (i != 5);
      apply();
      tick();
    end
    chk("t4_count", blog.size(), 4);
    if (blog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_data", blog[i].d, 8'h50 + 8'(i));
        chk("t4_last", blog[i].l, (i == 3));
      end
    end

    // 5: reset on the second beat of a source-1 packet
    do_reset();
    for (int i = 0; i < 5; i++) q1.push_back({(i == 4), 8'(8'h60 + i)});
    en1 = 1; rdy_k = 1;
    apply();
    repeat (2) tick();
    chk("t5_pre_count", blog.size(), 1);
    chk("t5_pre_sel", bus.sel, 1);
    rst_k = 1;
    apply();
    tick();
    rst_k = 0;
    q0.delete(); q1.delete(); blog.delete();
    apply();
    chk("t5_busy", bus.busy, 0);
    chk("t5_sel", bus.sel, 0);
    chk("t5_in1_ready", bus.in1_ready, 0);
    q0 = '{9'h178};
    q1 = '{9'h170};
    en0 = 1; en1 = 1;
    apply();
    repeat (8) tick();
    chk("t5_count", blog.size(), 2);
    if (blog.size() == 2) begin
      chk("t5_first", blog[0].d, 8'h78);
      chk("t5_first_sel", blog[0].s, 0);
      chk("t5_second", blog[1].d, 8'h70);
      chk("t5_second_sel", blog[1].s, 1);
    end

    // 6: back-to-back 1-beat packets on source 0
    do_reset();
    q0 = '{9'h180, 9'h181, 9'h182, 9'h183};
    en0 = 1; rdy_k = 1;
    apply();
    repeat (10) tick();
    chk("t6_count", blog.size(), 4);
    if (blog.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        chk("t6_spacing", blog[i].c - blog[i - 1].c, 2);
        chk("t6_sel", blog[i].s, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
